multicycle_controller: RTL
==========================

# multicycle_controller

Multi-cycle sequencer for the single-bus CPU datapath (PC, IR, register file, ALU, shared unified memory). Replaces the purely combinational decoder with a Moore state machine that steps each instruction (add, sub, ori, lw, sw, beq) through fetch, decode, execute, memory and write-back. It issues the same datapath select/enable signals cycle by cycle and waits on the memory ready handshake.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag, sampled in EXEC
- mem_ready  in  1  memory completes the current access this cycle
- MemRd  out  1  memory read request
- MemWr  out  1  memory write request
- IorD  out  1  0: memory address = PC; 1: address = ALU result register
- IRWr  out  1  load IR from memory data
- PCWr  out  1  load PC
- nPC_sel  out  1  0: PC+4; 1: branch target
- RegWr, RegDst, ExtOp, ALUSrc, MemtoReg  out  1 each  same meaning as existing decoder: RegDst 1 = rd; ExtOp 1 = sign; ALUSrc 1 = immediate; MemtoReg 1 = memory data
- ALUctr  out  3  010 add, 110 sub, 001 or
- state  out  3  current state, for debug
- illegal  out  1  sticky unsupported-instruction flag

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Codes 6 and 7 go to FETCH.
- Outputs are a Moore function of the state and the latched class register. Any output not listed for a state is 0. ALUctr defaults to 010.
- FETCH: MemRd=1, IorD=0.
  - While mem_ready=0: stay in FETCH.
  - When mem_ready=1: IRWr=1, PCWr=1, nPC_sel=0, next state DECODE.
- DECODE: decode opcode/funct into a one-hot class register {add, sub, ori, lw, sw, beq, bad}. Next state EXEC.
- EXEC: ALUctr = 010 for add/lw/sw, 001 for ori, 110 for sub/beq.
  - ALUSrc = ori|lw|sw; ExtOp = lw|sw.
  - add/sub/ori: next WB.
  - lw/sw: next MEM.
  - beq: nPC_sel=1 and PCWr=zero, next FETCH.
  - bad: see Configuration.
- MEM: IorD=1, MemRd=lw, MemWr=sw, ALUctr=010, ALUSrc=1, ExtOp=1, all held until mem_ready=1.
  - On mem_ready, lw goes to WB and sw goes to FETCH.
- WB: RegWr=1 for one cycle.
  - RegDst = add|sub.
  - MemtoReg = lw.
  - ALU controls held as in EXEC so the ALU result stays stable.
  - Next state FETCH.
- The class register updates only in DECODE. opcode/funct changes in other states are ignored.

## Timing
- Reset: when rst_n=0 at a clock edge, the next state is FETCH, the class register is cleared and illegal is cleared.
  - After reset the outputs are MemRd=1 and all others 0 (ALUctr=010).
- Reset asserted mid-operation (including MEM with MemWr=1): it takes effect at that edge, and MemWr/RegWr deassert in the following cycle. No partial write-back occurs.
- Cycles per instruction with mem_ready tied to 1: beq 3, add/sub/ori/sw 4, lw 5.
- Each cycle mem_ready is low in FETCH or MEM adds one cycle.
- MemRd/MemWr stay high from state entry until and including the mem_ready cycle. They drop in the next cycle.
- mem_ready outside FETCH/MEM is ignored.
- PCWr is high for exactly one cycle per fetch, plus one cycle for a taken beq.
- RegWr is high for at most one cycle per instruction.

## Configuration
- MC_ILLEGAL_TRAP_EN defined:
  - A bad class in EXEC goes to HALT.
  - HALT asserts illegal=1 with all enables 0, and stays there until reset.
  - illegal is registered, so it rises on the cycle HALT is entered.
- MC_ILLEGAL_TRAP_EN undefined:
  - A bad class in EXEC goes to FETCH with no writes (executes as a NOP).
  - illegal is tied to 0 and HALT is unreachable.

## Test plan
- add (opcode 00, funct 20), mem_ready=1 → states 0,1,2,4.
  - IRWr/PCWr in cycle 1, ALUctr=010 in EXEC, RegWr=1 with RegDst=1 in cycle 4.
  - Next fetch starts in cycle 5.
- lw (opcode 23), mem_ready low for 2 cycles in MEM → MEM lasts 3 cycles with IorD=1 and MemRd=1 throughout.
  - Then WB with MemtoReg=1 and RegWr=1; total 7 cycles.
- beq (opcode 04) with zero=1 → PCWr=1, nPC_sel=1 in EXEC, 3 cycles.
  - With zero=0 → PCWr=0 in EXEC and the next state is FETCH.
- sw (opcode 2B), rst_n dropped in the MEM cycle while MemWr=1 → next cycle state=0, MemWr=0, MemRd=1.
  - No RegWr seen.
- opcode 3F with MC_ILLEGAL_TRAP_EN → HALT (5) and illegal=1 after EXEC.
  - MemRd stays 0 for 10 cycles.
  - Without the macro → FETCH after EXEC, illegal=0, no RegWr/MemWr.
- ori (opcode 0D) with opcode changed to 2B during EXEC → ALUctr stays 001, ALUSrc=1, ExtOp=0.
  - WB with RegDst=0.

Source files
------------

// File: rtl/multicycle_controller.sv
// multicycle_controller
//
// Moore-style sequencer for the single-bus CPU datapath. Each instruction
// (add, sub, ori, lw, sw, beq) is stepped through FETCH, DECODE, EXEC,
// MEM and WB. The controller waits on the memory ready handshake in FETCH
// and MEM.
//
// Optional feature: define MC_ILLEGAL_TRAP_EN to trap unsupported
// instructions in HALT with a sticky illegal flag. Without the macro an
// unsupported instruction executes as a NOP and illegal is tied to 0.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   opcode     IR[31:26], valid from DECODE onward
//   funct      IR[5:0]
//   zero       ALU zero flag, sampled in EXEC
//   mem_ready  memory completes the current access this cycle
//   MemRd      memory read request
//   MemWr      memory write request
//   IorD       0: address = PC, 1: address = ALU result register
//   IRWr       load IR from memory data
//   PCWr       load PC
//   nPC_sel    0: PC+4, 1: branch target
//   RegWr      register file write enable
//   RegDst     1: destination is rd
//   ExtOp      1: sign-extend the immediate
//   ALUSrc     1: ALU B operand is the immediate
//   MemtoReg   1: write-back data comes from memory
//   ALUctr     010 add, 110 sub, 001 or
//   state      current state, for debug
//   illegal    sticky unsupported-instruction flag
module multicycle_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       MemRd,
    output logic       MemWr,
    output logic       IorD,
    output logic       IRWr,
    output logic       PCWr,
    output logic       nPC_sel,
    output logic       RegWr,
    output logic       RegDst,
    output logic       ExtOp,
    output logic       ALUSrc,
    output logic       MemtoReg,
    output logic [2:0] ALUctr,
    output logic [2:0] state,
    output logic       illegal
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    // Bit positions inside the one-hot instruction class register.
    localparam int C_ADD = 0;
    localparam int C_SUB = 1;
    localparam int C_ORI = 2;
    localparam int C_LW  = 3;
    localparam int C_SW  = 4;
    localparam int C_BEQ = 5;
    localparam int C_BAD = 6;

    state_t     state_r;
    state_t     state_nxt_s;
    logic [6:0] cls_r;
    logic [6:0] cls_nxt_s;
    logic       illegal_r;
    logic       illegal_nxt_s;
    logic [2:0] alu_exec_s;
    logic       alusrc_exec_s;
    logic       extop_exec_s;

    // Map opcode/funct to a one-hot class; anything unrecognised is bad.
    function automatic logic [6:0] decode_class(input logic [5:0] op, input logic [5:0] fn);
        logic [6:0] c;
        c = 7'b000_0000;
        case (op)
            6'h00: begin
                case (fn)
                    6'h20:   c[C_ADD] = 1'b1;
                    6'h22:   c[C_SUB] = 1'b1;
                    default: c[C_BAD] = 1'b1;
                endcase
            end
            6'h0D:   c[C_ORI] = 1'b1;
            6'h23:   c[C_LW]  = 1'b1;
            6'h2B:   c[C_SW]  = 1'b1;
            6'h04:   c[C_BEQ] = 1'b1;
            default: c[C_BAD] = 1'b1;
        endcase
        return c;
    endfunction

    // ALU controls shared by EXEC and WB so the ALU result stays stable into write-back.
    assign alu_exec_s    = (cls_r[C_SUB] | cls_r[C_BEQ]) ? 3'b110 :
                           (cls_r[C_ORI]                 ? 3'b001 : 3'b010);
    assign alusrc_exec_s = cls_r[C_ORI] | cls_r[C_LW] | cls_r[C_SW];
    assign extop_exec_s  = cls_r[C_LW] | cls_r[C_SW];

    // State, class and illegal flag registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= S_FETCH;
            cls_r     <= 7'b000_0000;
            illegal_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cls_r     <= cls_nxt_s;
            illegal_r <= illegal_nxt_s;
        end
    end

    // Next-state, class latch and per-state datapath controls.
    always_comb begin
        state_nxt_s = state_r;
        cls_nxt_s   = cls_r;
        MemRd       = 1'b0;
        MemWr       = 1'b0;
        IorD        = 1'b0;
        IRWr        = 1'b0;
        PCWr        = 1'b0;
        nPC_sel     = 1'b0;
        RegWr       = 1'b0;
        RegDst      = 1'b0;
        ExtOp       = 1'b0;
        ALUSrc      = 1'b0;
        MemtoReg    = 1'b0;
        ALUctr      = 3'b010;
        case (state_r)
            S_FETCH: begin
                MemRd = 1'b1;
                if (mem_ready) begin
                    IRWr        = 1'b1;
                    PCWr        = 1'b1;
                    state_nxt_s = S_DECODE;
                end else begin
                    state_nxt_s = S_FETCH;
                end
            end
            S_DECODE: begin
                cls_nxt_s   = decode_class(opcode, funct);
                state_nxt_s = S_EXEC;
            end
            S_EXEC: begin
                ALUctr = alu_exec_s;
                ALUSrc = alusrc_exec_s;
                ExtOp  = extop_exec_s;
                if (cls_r[C_ADD] | cls_r[C_SUB] | cls_r[C_ORI]) begin
                    state_nxt_s = S_WB;
                end else if (cls_r[C_LW] | cls_r[C_SW]) begin
                    state_nxt_s = S_MEM;
                end else if (cls_r[C_BEQ]) begin
                    nPC_sel     = 1'b1;
                    PCWr        = zero;
                    state_nxt_s = S_FETCH;
                end else begin
`ifdef MC_ILLEGAL_TRAP_EN
                    state_nxt_s = S_HALT;
`else
                    state_nxt_s = S_FETCH;
`endif
                end
            end
            S_MEM: begin
                IorD   = 1'b1;
                MemRd  = cls_r[C_LW];
                MemWr  = cls_r[C_SW];
                ALUctr = 3'b010;
                ALUSrc = 1'b1;
                ExtOp  = 1'b1;
                if (!mem_ready) begin
                    state_nxt_s = S_MEM;
                end else if (cls_r[C_LW]) begin
                    state_nxt_s = S_WB;
                end else begin
                    state_nxt_s = S_FETCH;
                end
            end
            S_WB: begin
                RegWr       = 1'b1;
                RegDst      = cls_r[C_ADD] | cls_r[C_SUB];
                MemtoReg    = cls_r[C_LW];
                ALUctr      = alu_exec_s;
                ALUSrc      = alusrc_exec_s;
                ExtOp       = extop_exec_s;
                state_nxt_s = S_FETCH;
            end
            S_HALT: begin
`ifdef MC_ILLEGAL_TRAP_EN
                state_nxt_s = S_HALT;
`else
                state_nxt_s = S_FETCH;
`endif
            end
            default: begin
                state_nxt_s = S_FETCH;
            end
        endcase
    end

`ifdef MC_ILLEGAL_TRAP_EN
    // Sticky: rises together with the entry into HALT, cleared only by reset.
    assign illegal_nxt_s = illegal_r | (state_nxt_s == S_HALT);
`else
    assign illegal_nxt_s = 1'b0;
`endif

    assign state   = state_r;
    assign illegal = illegal_r;

endmodule
